// File: rtl/uart_pkg.sv
// UART memory-mapped peripheral: register map, STATUS bit indices
// and the TX/RX state encodings shared by the uart_mem slice.
package uart_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  localparam int STAT_TX_BUSY   = 0;
  localparam int STAT_RX_VALID  = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// RX byte FIFO for uart_mem (power-of-two depth).
// Push and pop may happen together, including while full.
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rp_q];

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wp_d    = wp_q + AW'(do_push);
    rp_d    = rp_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

endmodule

// File: rtl/uart_mem.sv
// UART with memory-mapped DATA/STATUS/DIV registers.
// Define UART_RX_FIFO_EN to buffer received bytes in uart_fifo.
module uart_mem
  import uart_pkg::*;
#(
  parameter int CLK_DIV_RESET = 217,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  logic [15:0] div_q, div_d, div_m;
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_last, tx_busy;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_last;

  logic [1:0]  sel;
  logic        req, wr, go, data_wr, tx_load;
  logic        rx_pop, stat_wr, div_wr;
  logic        rx_done, ferr_set, ovr_set, rx_store;
  logic        rx_valid, rx_full;
  logic [7:0]  rx_byte, stat;
  logic [3:0]  rx_occ;

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign tx_busy   = (tx_state_q != TX_IDLE);

  // A DATA write waits here while the transmitter is busy.
  always_comb begin
    sel     = mem_addr[3:2];
    wr      = |mem_wstrb;
    req     = mem_valid & ~ready_q;
    data_wr = req & mem_wstrb[0] & (sel == REG_DATA);
    go      = req & ~(data_wr & tx_busy);
    tx_load = go & data_wr;
    rx_pop  = go & ~wr & (sel == REG_DATA) & rx_valid;
    stat_wr = go & mem_wstrb[0] & (sel == REG_STAT);
    div_wr  = go & (|mem_wstrb[1:0]) & (sel == REG_DIV);
  end

  always_comb begin
    div_m = div_q;
    if (mem_wstrb[0]) div_m[7:0]  = mem_wdata[7:0];
    if (mem_wstrb[1]) div_m[15:8] = mem_wdata[15:8];
    div_d = div_q;
    if (div_wr) div_d = (div_m < DIV_MIN) ? DIV_MIN : div_m;
  end

  always_comb begin
    stat                 = '0;
    stat[STAT_TX_BUSY]   = tx_busy;
    stat[STAT_RX_VALID]  = rx_valid;
    stat[STAT_OVERRUN]   = ovr_q;
    stat[STAT_FRAME_ERR] = ferr_q;
    stat[7:4]            = rx_occ;
  end

  always_comb begin
    rdata_d = '0;
    if (go && !wr) begin
      unique case (sel)
        REG_DATA: rdata_d = {24'b0, rx_valid ? rx_byte : 8'h00};
        REG_STAT: rdata_d = {24'b0, stat};
        REG_DIV:  rdata_d = {16'b0, div_q};
        REG_RSVD: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    ovr_set  = rx_done & rx_full & ~rx_pop;
    rx_store = rx_done & ~ovr_set;
    ovr_d    = ovr_set |
               (ovr_q & ~(stat_wr & mem_wdata[STAT_OVERRUN]));
    ferr_d   = ferr_set |
               (ferr_q & ~(stat_wr & mem_wdata[STAT_FRAME_ERR]));
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_last    = (tx_cnt_q == tx_div_q - 16'd1);
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_load) begin
          tx_state_d = TX_START;
          tx_div_d   = div_q;
          tx_sh_d    = mem_wdata[7:0];
        end
      end
      TX_START: if (tx_last) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_last) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_last) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  assign uart_txd = (tx_state_q == TX_START) ? 1'b0 :
                    (tx_state_q == TX_DATA)  ? tx_sh_q[0] : 1'b1;

  // START checks mid-bit so a short low glitch is rejected.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_done    = 1'b0;
    ferr_set   = 1'b0;
    rx_last    = (rx_cnt_q == rx_div_q - 16'd1);
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_div_d   = div_q;
        end
      end
      RX_START: if (rx_cnt_q == {1'b0, rx_div_q[15:1]}) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_last) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_last) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        rx_done    = rx_sync_q;
        ferr_set   = ~rx_sync_q;
      end
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int CntW = $clog2(RX_FIFO_DEPTH) + 1;
  logic [CntW-1:0] fifo_cnt;
  logic            fifo_full, fifo_empty;
  logic            unused_ok;

  uart_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_store),
    .data_i  (rx_sh_q),
    .pop_i   (rx_pop),
    .data_o  (rx_byte),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid  = ~fifo_empty;
  assign rx_full   = fifo_full;
  assign rx_occ    = 4'(fifo_cnt);
  assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:16]};
`else
  localparam logic [31:0] FifoDepth = RX_FIFO_DEPTH;
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       unused_ok;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (rx_pop) hold_vld_d = 1'b0;
    if (rx_store) begin
      hold_d     = rx_sh_q;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign rx_valid  = hold_vld_q;
  assign rx_full   = hold_vld_q;
  assign rx_byte   = hold_q;
  assign rx_occ    = '0;
  assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:16], FifoDepth[0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= 16'(CLK_DIV_RESET);
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'(CLK_DIV_RESET);
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= 16'(CLK_DIV_RESET);
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      div_q      <= div_d;
      ready_q    <= go;
      rdata_q    <= rdata_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_meta_q  <= uart_rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

endmodule

// File: tb/tb_uart_mem.sv
// Self-checking bench for uart_mem: bus reads, TX frames and
// RX bytes are checked against scoreboard queues and a flag model.
module tb_uart_mem;

  localparam int CLK_NS = 10;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;

  uart_mem dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .uart_rxd  (uart_rxd),
    .uart_txd  (uart_txd)
  );

  always #(CLK_NS/2) clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cur_div = 217;
  logic        m_ovr = 1'b0;
  logic        m_ferr = 1'b0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp(input logic busy);
    logic [3:0] occ = '0;
`ifdef UART_RX_FIFO_EN
    occ = 4'(rx_q.size());
`endif
    return {24'b0, occ, m_ferr, m_ovr, rx_q.size() != 0, busy};
  endfunction

  task automatic bus(input string tag, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, output realtime t);
    int cyc = 0;
    rd_q.push_back(exp);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_ready && cyc < 2000);
    t = $realtime;
    if (!mem_ready) chk({tag, " timeout"}, 32'(mem_ready), 32'd1);
    chk(tag, mem_rdata, rd_q.pop_front());
    mem_valid = 1'b0;
    mem_wstrb = '0;
    mem_wdata = '0;
    @(negedge clk);
    chk({tag, " pulse"}, 32'(mem_ready), 32'd0);
    chk({tag, " rdata idle"}, mem_rdata, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [31:0] exp);
    realtime t;
    bus(tag, a, 32'd0, 4'h0, exp, t);
  endtask

  task automatic wr(input string tag, input logic [3:0] a,
                    input logic [31:0] d, input logic [3:0] s);
    realtime t;
    bus(tag, a, d, s, 32'd0, t);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] exp = '0;
    if (rx_q.size() != 0) exp = 32'(rx_q.pop_front());
    rd(tag, 4'h0, exp);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (cur_div) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    if (!stop) m_ferr = 1'b1;
    else if (rx_q.size() < CAP) rx_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && uart_txd === 1'b0) begin
        logic [7:0] e;
        repeat (cur_div/2 - 1) @(negedge clk);
        chk("tx start", 32'(uart_txd), 32'd0);
        if (tx_q.size() == 0) begin
          chk("tx unexpected frame", 32'(tx_q.size()), 32'd1);
          e = 8'h00;
        end else begin
          e = tx_q.pop_front();
        end
        for (int i = 0; i < 8; i++) begin
          repeat (cur_div) @(negedge clk);
          chk($sformatf("tx bit%0d", i), 32'(uart_txd), 32'(e[i]));
        end
        repeat (cur_div) @(negedge clk);
        chk("tx stop", 32'(uart_txd), 32'd1);
      end
    end
  end

  initial begin
    realtime t1, t2;
    repeat (3) @(negedge clk);
    chk("rst txd", 32'(uart_txd), 32'd1);
    chk("rst ready", 32'(mem_ready), 32'd0);
    chk("rst rdata", mem_rdata, 32'd0);
    rst = 1'b0;

    rd("status reset", 4'h4, status_exp(1'b0));
    rd("div reset", 4'h8, 32'd217);
    wr("rsvd write", 4'hC, 32'hFFFF_FFFF, 4'hF);
    rd("rsvd read", 4'hC, 32'd0);

    wr("div small", 4'h8, 32'd2, 4'h3);
    rd("div clamp", 4'h8, 32'd4);
    wr("div full", 4'h8, 32'hDEAD_0008, 4'hF);
    rd("div upper", 4'h8, 32'd8);
    wr("div lo", 4'h8, 32'h0000_0305, 4'h1);
    rd("div strobe", 4'h8, 32'd5);
    wr("div 8", 4'h8, 32'd8, 4'h3);
    cur_div = 8;

    wr("data no strb0", 4'h0, 32'h11, 4'h2);
    tx_q.push_back(8'hA5);
    bus("tx a5", 4'h0, 32'hA5, 4'h1, 32'd0, t1);
    tx_q.push_back(8'h3C);
    bus("tx 3c", 4'h0, 32'h3C, 4'h1, 32'd0, t2);
    chk("stall latency", 32'($rtoi((t2 - t1) / CLK_NS)), 32'(10*8 + 1));
    rd("status busy", 4'h4, status_exp(1'b1));
    repeat (100) @(negedge clk);
    rd("status tx idle", 4'h4, status_exp(1'b0));

    uart_send(8'h5A, 1'b1);
    rd("status rx valid", 4'h4, status_exp(1'b0));
    rd_data("rx 5a");
    rd("status rx popped", 4'h4, status_exp(1'b0));
    rd_data("rx empty");
    rd("status after empty", 4'h4, status_exp(1'b0));

    uart_send(8'h77, 1'b0);
    rd("status frame err", 4'h4, status_exp(1'b0));
    wr("clr frame err", 4'h4, 32'h8, 4'h1);
    m_ferr = 1'b0;
    rd("status ferr clr", 4'h4, status_exp(1'b0));

    for (int i = 0; i <= CAP; i++) uart_send(8'h30 + 8'(i), 1'b1);
    rd("status overrun", 4'h4, status_exp(1'b0));
    for (int i = 0; i < CAP; i++) rd_data("rx kept");
    wr("clr overrun", 4'h4, 32'h4, 4'h1);
    m_ovr = 1'b0;
    rd("status ovr clr", 4'h4, status_exp(1'b0));

    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    rd("status glitch", 4'h4, status_exp(1'b0));

    uart_rxd = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst mid txd", 32'(uart_txd), 32'd1);
    chk("rst mid ready", 32'(mem_ready), 32'd0);
    uart_rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_div = 217;
    rx_q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    repeat (10) @(negedge clk);
    rd("status post rst", 4'h4, status_exp(1'b0));
    rd_data("rx post rst");
    rd("div post rst", 4'h8, 32'd217);

    chk("tx drained", 32'(tx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
